// File: rtl/dpsk_pkg.sv
// dpsk_pkg: shared definitions for the DPSK loopback demo.
//   - sample / product / accumulator widths and their signed types
//   - transmitter state typedef (IDLE / REF / DATA)
//   - one-period sine carrier table and the BPSK sample helper
package dpsk_pkg;

  localparam int SAMPLE_W = 8;
  localparam int PROD_W   = 2 * SAMPLE_W;
  // Eight products of at most 127*127 each sum to 129032, so three guard bits
  // above the product width are enough.
  localparam int ACC_W    = PROD_W + 3;
  localparam int LUT_N    = 8;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [PROD_W-1:0]   prod_t;
  typedef logic signed [ACC_W-1:0]    acc_t;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_REF  = 2'd1,
    TX_DATA = 2'd2
  } tx_state_t;

  // One full carrier period; the sample index walks it once per symbol.
  localparam sample_t SINE_LUT [LUT_N] = '{
    8'sd0, 8'sd90, 8'sd127, 8'sd90, 8'sd0, -8'sd90, -8'sd127, -8'sd90
  };

  // BPSK: the encoder state selects the carrier polarity.
  function automatic sample_t modulate(input logic [2:0] idx, input logic flip);
    sample_t base;
    base = SINE_LUT[idx];
    if (flip) begin
      return -base;
    end else begin
      return base;
    end
  endfunction

endpackage

// File: rtl/dpsk_if.sv
// dpsk_if: carrier sample stream from the modulator to the demodulator.
//   sample    : signed carrier sample, one per clock
//   valid     : sample belongs to a transmitted symbol
//   last      : final sample of the current symbol
//   ref_sym   : sample belongs to the reference symbol (no data decision)
//   first_bit : sample belongs to bit 0 (MSB) of a word
interface dpsk_if;
  import dpsk_pkg::*;

  sample_t sample;
  logic    valid;
  logic    last;
  logic    ref_sym;
  logic    first_bit;

  modport master (output sample, valid, last, ref_sym, first_bit);
  modport slave  (input  sample, valid, last, ref_sym, first_bit);

endinterface

// File: rtl/dpsk_demod.sv
// dpsk_demod: delay-and-multiply differential demodulator.
//   clk1, rst        : clock and synchronous active-high reset
//   clear            : restart strobe; drops any partially accumulated symbol
//   rx               : sample stream (slave side)
//   demodulated      : recovered bit, registered, held for one symbol
//   neg_demodulated  : registered complement of demodulated
//   new_word         : one-cycle pulse when bit 0 of a word is presented
module dpsk_demod
  import dpsk_pkg::*;
#(
  parameter int SPS = 8
) (
  input  logic   clk1,
  input  logic   rst,
  input  logic   clear,
  dpsk_if.slave  rx,
  output logic   demodulated,
  output logic   neg_demodulated,
  output logic   new_word
);

  sample_t dly_r [SPS];
  prod_t   prod_r;
  logic    pv_r;
  logic    pl_r;
  logic    pref_r;
  logic    pfirst_r;
  acc_t    acc_r;
  acc_t    acc_sum_s;

  // The product register adds one cycle; the framing flags travel with it.
  assign acc_sum_s = acc_r + acc_t'(prod_r);

  // Sample delay line: dly_r[SPS-1] is the sample from one symbol earlier.
  always_ff @(posedge clk1) begin
    if (rst) begin
      for (int i = 0; i < SPS; i++) begin
        dly_r[i] <= '0;
      end
    end else begin
      dly_r[0] <= rx.sample;
      for (int i = 1; i < SPS; i++) begin
        dly_r[i] <= dly_r[i-1];
      end
    end
  end

  // Multiply, accumulate over a symbol and decide on the sign at symbol end.
  always_ff @(posedge clk1) begin
    if (rst) begin
      prod_r          <= '0;
      pv_r            <= 1'b0;
      pl_r            <= 1'b0;
      pref_r          <= 1'b0;
      pfirst_r        <= 1'b0;
      acc_r           <= '0;
      demodulated     <= 1'b0;
      neg_demodulated <= 1'b1;
      new_word        <= 1'b0;
    end else begin
      prod_r <= prod_t'(rx.sample) * prod_t'(dly_r[SPS-1]);
      if (clear) begin
        // Restart: discard the interrupted symbol, keep the last decision.
        pv_r     <= 1'b0;
        pl_r     <= 1'b0;
        pref_r   <= 1'b0;
        pfirst_r <= 1'b0;
        acc_r    <= '0;
        new_word <= 1'b0;
      end else begin
        pv_r     <= rx.valid;
        pl_r     <= rx.last;
        pref_r   <= rx.ref_sym;
        pfirst_r <= rx.first_bit;
        new_word <= 1'b0;
        if (pv_r) begin
          if (pl_r) begin
            acc_r <= '0;
            // A phase reversal between symbols gives a negative correlation.
            if (!pref_r) begin
              demodulated     <= acc_sum_s[ACC_W-1];
              neg_demodulated <= ~acc_sum_s[ACC_W-1];
              new_word        <= pfirst_r;
            end
          end else begin
            acc_r <= acc_sum_s;
          end
        end
      end
    end
  end

endmodule

// File: rtl/dpsk_top.sv
// dpsk_top: self-contained DPSK loopback demo.
//   clk1             : system clock
//   rst              : synchronous active-high reset (priority over load)
//   load             : start/restart strobe
//   demodulated      : recovered data bit, registered
//   neg_demodulated  : registered complement of demodulated
//   new_word         : one-cycle pulse marking the MSB of each recovered word
// The transmitter sends a reference symbol followed by INIT_WORD repeated
// forever, MSB first, differentially encoded and BPSK-modulated onto a
// one-period-per-symbol sine carrier. dpsk_demod recovers the bitstream.
module dpsk_top
  import dpsk_pkg::*;
#(
  parameter int              WORD_W    = 8,
  parameter int              SPS       = 8,
  parameter logic [WORD_W-1:0] INIT_WORD = 8'hB4
) (
  input  logic clk1,
  input  logic rst,
  input  logic load,
  output logic demodulated,
  output logic neg_demodulated,
  output logic new_word
);

  localparam int                IDX_W    = $clog2(SPS);
  localparam int                BIT_W    = $clog2(WORD_W);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(SPS - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(WORD_W - 1);

  tx_state_t         state_r;
  logic [WORD_W-1:0] word_r;
  logic [BIT_W-1:0]  bit_idx_r;
  logic [IDX_W-1:0]  samp_idx_r;
  logic              enc_r;
  sample_t           sample_r;
  logic              valid_r;
  logic              last_r;
  logic              ref_r;
  logic              first_r;

  dpsk_if tx_if ();

  assign tx_if.sample    = sample_r;
  assign tx_if.valid     = valid_r;
  assign tx_if.last      = last_r;
  assign tx_if.ref_sym   = ref_r;
  assign tx_if.first_bit = first_r;

  // Transmitter FSM, differential encoder and modulator output register.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_r    <= TX_IDLE;
      word_r     <= '0;
      bit_idx_r  <= '0;
      samp_idx_r <= '0;
      enc_r      <= 1'b0;
      sample_r   <= '0;
      valid_r    <= 1'b0;
      last_r     <= 1'b0;
      ref_r      <= 1'b0;
      first_r    <= 1'b0;
    end else if (load) begin
      state_r    <= TX_REF;
      word_r     <= INIT_WORD;
      bit_idx_r  <= '0;
      samp_idx_r <= '0;
      enc_r      <= 1'b0;
      sample_r   <= '0;
      valid_r    <= 1'b0;
      last_r     <= 1'b0;
      ref_r      <= 1'b0;
      first_r    <= 1'b0;
    end else begin
      case (state_r)
        TX_IDLE: begin
          sample_r <= '0;
          valid_r  <= 1'b0;
          last_r   <= 1'b0;
          ref_r    <= 1'b0;
          first_r  <= 1'b0;
        end
        TX_REF, TX_DATA: begin
          sample_r <= modulate(3'(samp_idx_r), enc_r);
          valid_r  <= 1'b1;
          last_r   <= (samp_idx_r == LAST_IDX);
          ref_r    <= (state_r == TX_REF);
          first_r  <= (state_r == TX_DATA) && (bit_idx_r == '0);
          if (samp_idx_r == LAST_IDX) begin
            samp_idx_r <= '0;
            // The encoder state for the next symbol folds in that symbol's bit,
            // so it is ready on the first sample of the new symbol.
            if (state_r == TX_REF) begin
              state_r <= TX_DATA;
              enc_r   <= enc_r ^ word_r[WORD_W-1];
            end else if (bit_idx_r == LAST_BIT) begin
              word_r    <= INIT_WORD;
              bit_idx_r <= '0;
              enc_r     <= enc_r ^ INIT_WORD[WORD_W-1];
            end else begin
              word_r    <= word_r << 1;
              bit_idx_r <= bit_idx_r + 1'b1;
              enc_r     <= enc_r ^ word_r[WORD_W-2];
            end
          end else begin
            samp_idx_r <= samp_idx_r + 1'b1;
          end
        end
        default: begin
          state_r  <= TX_IDLE;
          sample_r <= '0;
          valid_r  <= 1'b0;
          last_r   <= 1'b0;
          ref_r    <= 1'b0;
          first_r  <= 1'b0;
        end
      endcase
    end
  end

  dpsk_demod #(
    .SPS (SPS)
  ) u_demod (
    .clk1            (clk1),
    .rst             (rst),
    .clear           (load),
    .rx              (tx_if),
    .demodulated     (demodulated),
    .neg_demodulated (neg_demodulated),
    .new_word        (new_word)
  );

endmodule

// File: tb/tb_dpsk_top.sv
module tb_dpsk_top;

  logic       clk1 = 1'b0;
  logic       rst  = 1'b1;
  logic       load = 1'b0;
  logic [2:0] dm;
  logic [2:0] ndm;
  logic [2:0] nw;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [7:0] words [3] = '{8'hB4, 8'hFF, 8'h00};
  int         lut   [8] = '{0, 90, 127, 90, 0, -90, -127, -90};
  bit         running = 1'b0;
  int         d = 0;
  logic       e_m = 1'b0;
  logic       exp_d  [3];
  logic       exp_nw [3];
  int         exp_s = 0;
  logic       exp_v = 1'b0;
  logic       exp_l = 1'b0;
  logic       exp_r = 1'b0;
  logic       exp_f = 1'b0;

  always #5 clk1 = ~clk1;

  dpsk_top #(.INIT_WORD(8'hB4)) dut (
    .clk1(clk1), .rst(rst), .load(load),
    .demodulated(dm[0]), .neg_demodulated(ndm[0]), .new_word(nw[0]));

  dpsk_top #(.INIT_WORD(8'hFF)) dut_ff (
    .clk1(clk1), .rst(rst), .load(load),
    .demodulated(dm[1]), .neg_demodulated(ndm[1]), .new_word(nw[1]));

  dpsk_top #(.INIT_WORD(8'h00)) dut_00 (
    .clk1(clk1), .rst(rst), .load(load),
    .demodulated(dm[2]), .neg_demodulated(ndm[2]), .new_word(nw[2]));

  // Observation bundle for the modulator stream of the B4 instance
  dpsk_if probe ();
  assign probe.sample    = dut.tx_if.sample;
  assign probe.valid     = dut.tx_if.valid;
  assign probe.last      = dut.tx_if.last;
  assign probe.ref_sym   = dut.tx_if.ref_sym;
  assign probe.first_bit = dut.tx_if.first_bit;

  task automatic check(input string nm, input logic signed [15:0] act,
                       input logic signed [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t, d=%0d)", nm, act, exp, $time, d);
    end
  endtask

  // Model advanced by one clock edge with the given inputs.
  task automatic model_edge(input logic r, input logic l);
    int m;
    if (r) begin
      running = 1'b0;
      d = 0;
      e_m = 1'b0;
      for (int k = 0; k < 3; k++) begin
        exp_d[k] = 1'b0;
        exp_nw[k] = 1'b0;
      end
    end else if (l) begin
      running = 1'b1;
      d = 0;
      e_m = 1'b0;
      for (int k = 0; k < 3; k++) exp_nw[k] = 1'b0;
    end else if (running) begin
      d++;
      // Data symbol s (s>=1) starts at d=1+8s and carries stream bit s-1.
      if (d >= 9 && (d - 1) % 8 == 0)
        e_m = e_m ^ words[0][7 - ((d - 9) / 8) % 8];
      for (int k = 0; k < 3; k++) begin
        exp_nw[k] = 1'b0;
        if (d >= 18 && (d - 18) % 8 == 0) begin
          m = (d - 18) / 8;
          exp_d[k] = words[k][7 - m % 8];
          exp_nw[k] = (m % 8 == 0);
        end
      end
    end else begin
      for (int k = 0; k < 3; k++) exp_nw[k] = 1'b0;
    end
    if (running && d >= 1) begin
      exp_s = e_m ? -lut[(d - 1) % 8] : lut[(d - 1) % 8];
      exp_v = 1'b1;
      exp_l = ((d - 1) % 8 == 7);
      exp_r = (d <= 8);
      exp_f = (d >= 9) && (((d - 9) / 8) % 8 == 0);
    end else begin
      exp_s = 0;
      exp_v = 1'b0;
      exp_l = 1'b0;
      exp_r = 1'b0;
      exp_f = 1'b0;
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("dut%0d demodulated", k), dm[k], exp_d[k]);
      check($sformatf("dut%0d neg_demodulated", k), ndm[k], !exp_d[k]);
      check($sformatf("dut%0d new_word", k), nw[k], exp_nw[k]);
    end
    check("tx sample", probe.sample, 16'(exp_s));
    check("tx valid", probe.valid, exp_v);
    check("tx last", probe.last, exp_l);
    check("tx ref_sym", probe.ref_sym, exp_r);
    check("tx first_bit", probe.first_bit, exp_f);
  endtask

  task automatic step(input logic r, input logic l);
    rst = r;
    load = l;
    @(posedge clk1);
    model_edge(r, l);
    @(negedge clk1);
    compare_all();
  endtask

  typedef struct {
    int   off;
    logic dem;
    logic nwd;
  } vec_t;

  vec_t vt [14];

  initial begin
    int vi;
    int d0;
    int pulses;
    int exp_pulses;
    int act;
    int len;

    vt[0]  = '{17, 1'b0, 1'b0};
    vt[1]  = '{18, 1'b1, 1'b1};
    vt[2]  = '{19, 1'b1, 1'b0};
    vt[3]  = '{25, 1'b1, 1'b0};
    vt[4]  = '{26, 1'b0, 1'b0};
    vt[5]  = '{34, 1'b1, 1'b0};
    vt[6]  = '{42, 1'b1, 1'b0};
    vt[7]  = '{50, 1'b0, 1'b0};
    vt[8]  = '{58, 1'b1, 1'b0};
    vt[9]  = '{66, 1'b0, 1'b0};
    vt[10] = '{74, 1'b0, 1'b0};
    vt[11] = '{81, 1'b0, 1'b0};
    vt[12] = '{82, 1'b1, 1'b1};
    vt[13] = '{83, 1'b1, 1'b0};

    @(negedge clk1);

    // Reset then idle without load: everything stays at reset values.
    step(1'b1, 1'b0);
    check("reset demodulated", dm[0], 1'b0);
    check("reset neg_demodulated", ndm[0], 1'b1);
    check("reset new_word", nw[0], 1'b0);
    repeat (50) step(1'b0, 1'b0);

    // Single load pulse: recovered B4 sequence against a fixed table.
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    vi = 0;
    for (int off = 1; off <= 90; off++) begin
      step(1'b0, 1'b0);
      if (vi < 14 && vt[vi].off == off) begin
        check($sformatf("table demodulated @+%0d", off), dm[0], vt[vi].dem);
        check($sformatf("table new_word @+%0d", off), nw[0], vt[vi].nwd);
        vi++;
      end
    end

    // Long run: pattern repeats, count new_word pulses.
    d0 = d;
    pulses = 0;
    repeat (1000) begin
      step(1'b0, 1'b0);
      if (nw[0] === 1'b1) pulses++;
    end
    exp_pulses = 0;
    for (int x = d0 + 1; x <= d0 + 1000; x++)
      if (x >= 18 && (x - 18) % 64 == 0) exp_pulses++;
    check("new_word pulse count", 16'(pulses), 16'(exp_pulses));

    // Restart in the middle of a bit.
    while (d % 8 != 3) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    for (int off = 1; off <= 30; off++) begin
      step(1'b0, 1'b0);
      if (off == 17) check("restart new_word @+17", nw[0], 1'b0);
      if (off == 18) begin
        check("restart new_word @+18", nw[0], 1'b1);
        check("restart first bit @+18", dm[0], 1'b1);
      end
    end

    // Reset mid-transmission: back to reset values, stays idle.
    repeat (13) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("mid reset demodulated", dm[0], 1'b0);
    check("mid reset neg_demodulated", ndm[0], 1'b1);
    check("mid reset new_word", nw[0], 1'b0);
    repeat (40) step(1'b0, 1'b0);
    check("idle after reset demodulated", dm[1], 1'b0);

    // Randomized operation against the model.
    for (int it = 0; it < 25; it++) begin
      act = $urandom_range(0, 9);
      if (act == 0) begin
        step(1'b1, 1'b0);
      end else if (act == 1) begin
        step(1'b1, 1'b1);
      end else if (act <= 8) begin
        len = $urandom_range(1, 3);
        repeat (len) step(1'b0, 1'b1);
      end else begin
        step(1'b0, 1'b0);
      end
      len = $urandom_range(5, 160);
      repeat (len) step(1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dpsk_top.md
Name: dpsk_top

Overview:
Self-contained DPSK loopback: an internal transmit word is differentially encoded and BPSK-modulated onto a sampled sine carrier. The samples are then differentially demodulated by delay-and-multiply correlation, recovering the bitstream serially. It is the top level of the DPSK demo design and has no external data path. The only controls are reset and a one-shot load/start.

Parameters:
WORD_W, 8, bits per transmitted word
SPS, 8, carrier samples per symbol (one full carrier period per symbol)
SAMPLE_W, 8, signed carrier sample width
INIT_WORD, 8'hB4, word transmitted after load; repeated continuously

Ports:
clk1  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
load  input  1  start/restart strobe, sampled on clk1
demodulated  output  1  recovered data bit, registered
neg_demodulated  output  1  always ~demodulated, registered
new_word  output  1  one-cycle pulse marking the MSB of each recovered word

Behaviour:
- Clock and reset: one clock, clk1. rst is synchronous and active-high.
- Reset values:
  - demodulated=0, neg_demodulated=1, new_word=0.
  - Internal state cleared; block idle.
- Idle: no samples generated (sample=0), outputs hold, until load is seen.
- load high at edge T, whether idle or running:
  - word_reg<=INIT_WORD, bit index=0, sample index=0, encoder state e=0.
  - Transmitter enters REF state.
  - rst has priority over load.
- Transmitter FSM: IDLE -> REF -> DATA, then DATA forever.
  - REF sends one reference symbol with e=0.
  - DATA sends word_reg MSB first, one bit per SPS cycles.
  - After WORD_W bits, word_reg reloads INIT_WORD with no gap and no new reference symbol. Differential state continues across words.
- Differential encode: at each symbol start, e <= e XOR bit.
- Modulator: 8-entry signed sine LUT {0,90,127,90,0,-90,-127,-90}, indexed by sample index.
  - Sample = e ? -LUT : +LUT.
  - One sample per cycle. REF samples occupy cycles T+1..T+8.
- Demodulator:
  - SPS-deep sample delay line.
  - Each cycle, product = sample * delayed sample (16-bit signed), summed into a 19-bit signed accumulator over one symbol.
  - At symbol end: bit = (acc < 0) ? 1 : 0, then the accumulator clears.
  - The REF symbol produces no output.
- Latency (defaults): bit k of word j appears on demodulated starting at edge T+18+8k+64j and holds for SPS cycles.
- new_word is high for exactly the one cycle in which demodulated first shows bit 0 of each word, i.e. at edges T+18+64j.
- neg_demodulated is registered in the same cycle as demodulated, so it is never equal to it.
- rst mid-operation: immediate return to reset values and IDLE. Restart requires load.
- load held high for several cycles: the sequence restarts each cycle; it runs from the last high cycle.

Decomposition:
- Shared package dpsk_pkg holds:
  - the sine LUT constant
  - the sample/product/accumulator widths
  - the transmitter state typedef (IDLE/REF/DATA)
- One natural sub-module: dpsk_demod (delay line, multiply-accumulate, decision, new_word framing).
- The transmitter, encoder and modulator stay in dpsk_top.

Test Plan:
- rst for 1 cycle, no load, run 50 cycles -> demodulated=0, neg_demodulated=1, new_word=0 throughout.
- rst, then load for 1 cycle at edge T -> demodulated sequence from T+18 in 8-cycle steps is 1,0,1,1,0,1,0,0. new_word is 1 only in the cycle after edge T+18.
- Run 1000 cycles after load -> pattern B4 repeats every 64 cycles, new_word pulses at T+18+64j, neg_demodulated == ~demodulated every cycle.
- INIT_WORD=8'hFF and INIT_WORD=8'h00 -> all-ones and all-zeros recovered respectively. Accumulator shows no overflow: correlation magnitude 64658 with the correct sign.
- load reasserted mid-word -> new REF symbol, and the first recovered bit after restart appears 18 cycles after the new load edge.
- rst asserted mid-transmission -> outputs return to reset values on the next edge and stay there until the next load.
